arbitro_registrador: RTL



---
 rtl/arbitro_registrador_pkg.sv | 28 ++
 rtl/arbitro_registrador_seletor_round_robin.sv | 38 +++
 rtl/arbitro_registrador.sv | 116 +++++++++++
 3 files changed

// File: rtl/arbitro_registrador_pkg.sv
// -----------------------------------------------------------------------------
// arbitro_registrador_pkg
//   Shared definitions for the round-robin write arbiter of the shared 7-bit
//   register: data width, FSM state encoding and the modulo-N index step used
//   by both the selector and the top-level pointer update.
// -----------------------------------------------------------------------------
package arbitro_registrador_pkg;

    localparam int unsigned LARGURA_DADO = 7;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESCRITA  = 2'd1,
        CONFIRMA = 2'd2,
        LIBERA   = 2'd3
    } estado_t;

    // Next requester index modulo n. The wrap is an explicit compare with n-1
    // because n need not be a power of two.
    function automatic logic [1:0] proximo_indice(input logic [1:0] atual,
                                                  input int unsigned n);
        if (atual == 2'(n - 1)) begin
            return 2'd0;
        end
        return atual + 2'd1;
    endfunction

endpackage

// File: rtl/arbitro_registrador_seletor_round_robin.sv
// -----------------------------------------------------------------------------
// seletor_round_robin
//   Combinational round-robin selector. Scans the request vector starting at
//   ponteiro_i and wrapping modulo N; the first set bit wins.
//
//   Ports:
//     req_i       in  N  request vector
//     ponteiro_i  in  2  index with highest priority this round (< N)
//     valido_o    out 1  at least one request is set
//     vencedor_o  out 2  index of the winning requester (0 when !valido_o)
// -----------------------------------------------------------------------------
module seletor_round_robin
    import arbitro_registrador_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [1:0]   ponteiro_i,
    output logic         valido_o,
    output logic [1:0]   vencedor_o
);

    logic [1:0] candidato;

    always_comb begin
        valido_o   = 1'b0;
        vencedor_o = '0;
        candidato  = ponteiro_i;
        for (int unsigned k = 0; k < N; k++) begin
            if (!valido_o && req_i[candidato]) begin
                valido_o   = 1'b1;
                vencedor_o = candidato;
            end
            candidato = proximo_indice(candidato, N);
        end
    end

endmodule

// File: rtl/arbitro_registrador.sv
// -----------------------------------------------------------------------------
// arbitro_registrador
//   Round-robin write arbiter/sequencer for a shared, always-loading 7-bit
//   register. The block drives the register's data input every cycle: the
//   granted requester's latched data for exactly one cycle (ESCRITA), the
//   reset value while rst is high, and the register's own output otherwise.
//   Each granted requester receives a one-cycle ack inside a four-phase
//   req/ack handshake; the next arbitration waits for that req to drop.
//
//   Ports:
//     clk          in  1      system clock, rising edge
//     rst          in  1      synchronous active-high reset
//     req          in  N      write request per requester
//     dados        in  7*N    write data, requester i at [7i+6:7i]
//     reg_saida    in  7      current output of the shared register
//     reg_entrada  out 7      data input of the shared register
//     ack          out N      one-hot write acknowledge
//     vencedor     out 2      granted requester index (valid when ocupado)
//     ocupado      out 1      high in every state except OCIOSO
// -----------------------------------------------------------------------------
module arbitro_registrador
    import arbitro_registrador_pkg::*;
#(
    parameter int unsigned                N             = 3,
    parameter logic [LARGURA_DADO-1:0]    VALOR_INICIAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N-1:0]                req,
    input  logic [LARGURA_DADO*N-1:0]   dados,
    input  logic [LARGURA_DADO-1:0]     reg_saida,
    output logic [LARGURA_DADO-1:0]     reg_entrada,
    output logic [N-1:0]                ack,
    output logic [1:0]                  vencedor,
    output logic                        ocupado
);

    estado_t                  estado_q,   estado_d;
    logic [1:0]               ponteiro_q, ponteiro_d;
    logic [1:0]               idx_q,      idx_d;
    logic [LARGURA_DADO-1:0]  dado_lat_q, dado_lat_d;

    logic                     sel_valido;
    logic [1:0]               sel_vencedor;

    seletor_round_robin #(
        .N (N)
    ) u_seletor (
        .req_i      (req),
        .ponteiro_i (ponteiro_q),
        .valido_o   (sel_valido),
        .vencedor_o (sel_vencedor)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= OCIOSO;
            ponteiro_q <= '0;
            idx_q      <= '0;
            dado_lat_q <= '0;
        end else begin
            estado_q   <= estado_d;
            ponteiro_q <= ponteiro_d;
            idx_q      <= idx_d;
            dado_lat_q <= dado_lat_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        ponteiro_d  = ponteiro_q;
        idx_d       = idx_q;
        dado_lat_d  = dado_lat_q;
        reg_entrada = reg_saida;
        ack         = '0;

        unique case (estado_q)
            OCIOSO: begin
                if (sel_valido) begin
                    idx_d      = sel_vencedor;
                    dado_lat_d = dados[int'(sel_vencedor)*LARGURA_DADO +: LARGURA_DADO];
                    estado_d   = ESCRITA;
                end
            end
            ESCRITA: begin
                reg_entrada = dado_lat_q;
                estado_d    = CONFIRMA;
            end
            CONFIRMA: begin
                ack[idx_q] = 1'b1;
                ponteiro_d = proximo_indice(idx_q, N);
                estado_d   = LIBERA;
            end
            LIBERA: begin
                // Nobody else is arbitrated until the served requester
                // completes the handshake by dropping its req.
                if (!req[idx_q]) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        // Reset overrides the mux so the register itself is initialised on
        // the same edge that resets the FSM, aborting any write in flight.
        if (rst) begin
            reg_entrada = VALOR_INICIAL;
        end
    end

    assign ocupado  = (estado_q != OCIOSO);
    assign vencedor = ocupado ? idx_q : 2'd0;

endmodule
